// File: rtl/qam_carrier_ctrl.sv
// qam_carrier_ctrl -- acquisition/tracking sequencer for the 16QAM carrier loop.
//
// Integrates |pd| over windows of 2^WIN_LOG2 accepted samples, classifies each
// window as good / neutral / bad against LOCK_TH / UNLOCK_TH, and walks the
// ACQ -> PULL -> TRACK -> LOST lock FSM. The FSM selects the loop-filter bandwidth
// and pulses the integrator clear.
//
// Optional feature macro: CARRIER_SWEEP_EN. When it is defined, every ACQ timeout
// steps a coarse NCO offset through 0, +S, -S, +2S, -2S, ... When it is not defined,
// sweep_df is tied to 0.
//
// Ports:
//   clk, rst   clock; synchronous active-high reset
//   en, pd     phase-detector valid and signed phase error (PW bits)
//   relock     level-sampled software re-acquire; forces LOST every cycle it is held
//   state      0=ACQ 1=PULL 2=TRACK 3=LOST
//   gain_sel   0 wide, 1 medium, 2 narrow (decoded from state)
//   loop_clr   integrator clear, high in the same cycle as the new state
//   locked     high only in TRACK
//   metric     sum of |pd| over the last completed window (unsigned)
//   sweep_df   signed NCO frequency offset
module qam_carrier_ctrl #(
    parameter int          PW          = 27,
    parameter int          WIN_LOG2    = 10,
    parameter logic [63:0] LOCK_TH     = 64'd1 << 30,
    parameter logic [63:0] UNLOCK_TH   = 64'd1 << 32,
    parameter int          LOCK_CNT    = 4,
    parameter int          ACQ_TIMEOUT = 64,
    parameter int          SWEEP_STEP  = 1 << 16,
    parameter int          SWEEP_MAX   = 1 << 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic signed [PW-1:0]   pd,
    input  logic                   relock,
    output logic [1:0]             state,
    output logic [1:0]             gain_sel,
    output logic                   loop_clr,
    output logic                   locked,
    output logic [PW+WIN_LOG2-1:0] metric,
    output logic signed [PW-1:0]   sweep_df
);
    localparam int MW  = PW + WIN_LOG2;
    localparam int GCW = $clog2(LOCK_CNT + 1);
    localparam int TCW = $clog2(ACQ_TIMEOUT + 1);
    localparam logic [GCW-1:0] LOCK_CNT_C = GCW'(LOCK_CNT);
    localparam logic [TCW-1:0] TMO_C      = TCW'(ACQ_TIMEOUT);

    localparam logic [1:0] ST_ACQ   = 2'd0;
    localparam logic [1:0] ST_PULL  = 2'd1;
    localparam logic [1:0] ST_TRACK = 2'd2;
    localparam logic [1:0] ST_LOST  = 2'd3;

    // Hysteresis only works with a gap between the two thresholds.
    if (UNLOCK_TH <= LOCK_TH || SWEEP_STEP <= 0 || SWEEP_MAX < SWEEP_STEP) begin : g_cfg_err
        $error("qam_carrier_ctrl: bad threshold or sweep configuration");
    end

    // ---------------- datapath: input reg -> |pd| reg -> accumulator ----------------
    logic [1:0]           vld_pipe;   // [0]: input stage valid, [1]: abs stage valid
    logic signed [PW-1:0] pd_q;
    logic [PW-1:0]        abs_pd, abs_nxt;
    logic [MW-1:0]        acc;
    logic [WIN_LOG2-1:0]  win_cnt;
    logic                 win_done;

    // -2^(PW-1) has no positive twin, so it saturates to the largest positive value.
    always_comb begin
        abs_nxt = pd_q;
        if (pd_q[PW-1])
            abs_nxt = (pd_q == {1'b1, {(PW-1){1'b0}}}) ? {1'b0, {(PW-1){1'b1}}} : -pd_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            pd_q     <= '0;
            abs_pd   <= '0;
            acc      <= '0;
            win_cnt  <= '0;
            win_done <= 1'b0;
            metric   <= '0;
        end else if (relock) begin
            // Restart the window from scratch; in-flight samples are dropped.
            vld_pipe <= '0;
            acc      <= '0;
            win_cnt  <= '0;
            win_done <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[0], en};
            pd_q     <= pd;
            abs_pd   <= abs_nxt;
            win_done <= 1'b0;
            if (vld_pipe[1]) begin
                win_cnt <= win_cnt + WIN_LOG2'(1);
                if (&win_cnt) begin
                    metric   <= acc + MW'(abs_pd);
                    acc      <= '0;
                    win_done <= 1'b1;
                end else begin
                    acc <= acc + MW'(abs_pd);
                end
            end
        end
    end

    // ---------------- lock FSM ----------------
    logic           metric_good, metric_bad;
    logic [GCW-1:0] good_cnt, bad_cnt, good_inc, bad_inc;
    logic [TCW-1:0] tmo_cnt, tmo_inc;

    assign metric_good = 64'(metric) <  LOCK_TH;
    assign metric_bad  = 64'(metric) >= UNLOCK_TH;
    // A neutral window (between thresholds) zeroes both runs.
    assign good_inc    = metric_good ? good_cnt + GCW'(1) : '0;
    assign bad_inc     = metric_bad  ? bad_cnt  + GCW'(1) : '0;
    assign tmo_inc     = tmo_cnt + TCW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_ACQ;
            loop_clr <= 1'b0;
            good_cnt <= '0;
            bad_cnt  <= '0;
            tmo_cnt  <= '0;
        end else begin
            loop_clr <= 1'b0;
            if (relock) begin
                state    <= ST_LOST;
                loop_clr <= 1'b1;
                good_cnt <= '0;
                bad_cnt  <= '0;
                tmo_cnt  <= '0;
            end else begin
                case (state)
                    ST_ACQ: if (win_done) begin
                        bad_cnt <= '0;
                        if (good_inc == LOCK_CNT_C) begin
                            state    <= ST_PULL;
                            good_cnt <= '0;
                            tmo_cnt  <= '0;
                        end else begin
                            good_cnt <= good_inc;
                            if (tmo_inc == TMO_C) begin
                                loop_clr <= 1'b1;
                                tmo_cnt  <= '0;
                            end else begin
                                tmo_cnt <= tmo_inc;
                            end
                        end
                    end
                    ST_PULL: if (win_done) begin
                        if (metric_bad) begin
                            state    <= ST_ACQ;
                            loop_clr <= 1'b1;
                            good_cnt <= '0;
                        end else if (good_inc == LOCK_CNT_C) begin
                            state    <= ST_TRACK;
                            good_cnt <= '0;
                        end else begin
                            good_cnt <= good_inc;
                        end
                    end
                    ST_TRACK: if (win_done) begin
                        good_cnt <= '0;
                        if (bad_inc == LOCK_CNT_C) begin
                            state    <= ST_LOST;
                            loop_clr <= 1'b1;
                            bad_cnt  <= '0;
                        end else begin
                            bad_cnt <= bad_inc;
                        end
                    end
                    default: begin
                        // LOST is a single-cycle state that hands over to ACQ.
                        state    <= ST_ACQ;
                        good_cnt <= '0;
                        bad_cnt  <= '0;
                        tmo_cnt  <= '0;
                    end
                endcase
            end
        end
    end

    assign gain_sel = (state == ST_PULL) ? 2'd1 : (state == ST_TRACK) ? 2'd2 : 2'd0;
    assign locked   = (state == ST_TRACK);

    // ---------------- coarse frequency sweep ----------------
`ifdef CARRIER_SWEEP_EN
    localparam logic signed [PW-1:0] SSTEP = PW'(SWEEP_STEP);
    localparam logic signed [PW-1:0] SMAX  = PW'(SWEEP_MAX);

    logic                 sweep_adv;
    logic signed [PW-1:0] sw_mag, sw_next;

    // Same condition that produces the ACQ timeout clear above.
    assign sweep_adv = !relock && (state == ST_ACQ) && win_done &&
                       (good_inc != LOCK_CNT_C) && (tmo_inc == TMO_C);

    // 0 -> +S -> -S -> +2S -> -2S ... ; once the next positive step would pass
    // SWEEP_MAX the walk restarts at 0.
    always_comb begin
        sw_mag = (sweep_df < 0) ? -sweep_df : sweep_df;
        if (sweep_df > 0)
            sw_next = -sweep_df;
        else if (sw_mag + SSTEP > SMAX)
            sw_next = '0;
        else
            sw_next = sw_mag + SSTEP;
    end

    always_ff @(posedge clk) begin
        if (rst || relock)
            sweep_df <= '0;
        else if (sweep_adv)
            sweep_df <= sw_next;
    end
`else
    assign sweep_df = '0;
`endif

endmodule

// File: tb/tb_qam_carrier_ctrl.sv
// Scoreboard bench for qam_carrier_ctrl: every change of the observable output
// tuple is an event, compared in order against the expected events queued by
// the stimulus thread. A few exact-latency checks are made directly.
module tb_qam_carrier_ctrl;
    localparam int PW  = 27;
    localparam int WL  = 4;
    localparam int MW  = PW + WL;
    localparam logic [MW-1:0] M_SAT = MW'(64'd16 * 64'd67108863);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 en = 1'b0;
    logic                 relock = 1'b0;
    logic signed [PW-1:0] pd = '0;
    logic [1:0]           state, gain_sel;
    logic                 loop_clr, locked;
    logic [MW-1:0]        metric;
    logic signed [PW-1:0] sweep_df;

    qam_carrier_ctrl #(
        .PW(PW), .WIN_LOG2(WL), .LOCK_TH(64'd160), .UNLOCK_TH(64'd480),
        .LOCK_CNT(2), .ACQ_TIMEOUT(3), .SWEEP_STEP(10), .SWEEP_MAX(20)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .pd(pd), .relock(relock),
        .state(state), .gain_sel(gain_sel), .loop_clr(loop_clr), .locked(locked),
        .metric(metric), .sweep_df(sweep_df)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]           st;
        logic [1:0]           gs;
        logic                 lc;
        logic                 lk;
        logic [MW-1:0]        m;
        logic signed [PW-1:0] sw;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

`ifdef CARRIER_SWEEP_EN
    int sw_seq[5] = '{10, -10, 20, -20, 0};
`else
    int sw_seq[5] = '{0, 0, 0, 0, 0};
`endif

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // Queue one expected output tuple; gain and lock follow from the state.
    task automatic ex(input logic [1:0] st, input logic lc, input logic [MW-1:0] m, input int sw);
        ev_t e;
        e.st = st;
        e.gs = (st == 2'd1) ? 2'd1 : (st == 2'd2) ? 2'd2 : 2'd0;
        e.lc = lc;
        e.lk = (st == 2'd2);
        e.m  = m;
        e.sw = PW'(sw);
        exp_q.push_back(e);
    endtask

    task automatic send(input int n, input int v);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            en = 1'b1;
            pd = PW'(v);
        end
    endtask

    // Monitor: one comparison per change of the output tuple.
    initial begin
        ev_t prev, cur, e;
        prev = '0;
        forever begin
            @(posedge clk);
            #1;
            cur = '{state, gain_sel, loop_clr, locked, metric, sweep_df};
            if (rst) begin
                prev = cur;
            end else if (cur !== prev) begin
                prev = cur;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL event: unexpected st=%0d gs=%0d lc=%0d lk=%0d m=%0d sw=%0d",
                             cur.st, cur.gs, cur.lc, cur.lk, cur.m, cur.sw);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        errors++;
                        $display("FAIL event: got st=%0d gs=%0d lc=%0d lk=%0d m=%0d sw=%0d, expected st=%0d gs=%0d lc=%0d lk=%0d m=%0d sw=%0d",
                                 cur.st, cur.gs, cur.lc, cur.lk, cur.m, cur.sw,
                                 e.st, e.gs, e.lc, e.lk, e.m, e.sw);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d events pending", exp_q.size());
        $fatal(1);
    end

    initial begin
        // Power-on reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_state", state, 0);
        chk("reset_gain", gain_sel, 0);
        chk("reset_locked", locked, 0);
        chk("reset_loop_clr", loop_clr, 0);
        chk("reset_metric", metric, 0);
        chk("reset_sweep", sweep_df, 0);

        // Acquire with pd=+5 (metric 80)
        ex(0, 0, 80, 0);
        ex(1, 0, 80, 0);
        ex(2, 0, 80, 0);
        send(32, 5);
        send(3, 5);
        chk("pull_not_early", state, 0);
        send(1, 5);
        chk("pull_latency", state, 1);
        chk("pull_gain", gain_sel, 1);
        send(28, 5);
        send(4, 5);
        chk("track_state", state, 2);
        chk("track_gain", gain_sel, 2);
        chk("track_locked", locked, 1);
        send(12, 5);

        // Hysteresis: one bad window is forgiven, two lose lock
        ex(2, 0, 640, 0);
        ex(2, 0, 80, 0);
        send(16, -40);
        send(16, 5);
        ex(2, 0, 640, 0);
        ex(3, 1, 640, 0);
        ex(0, 0, 640, 0);
        send(32, -40);

        // ACQ timeout every 3 bad windows, with sweep steps
        ex(0, 0, 1600, 0);
        for (int k = 0; k < 5; k++) begin
            ex(0, 1, 1600, sw_seq[k]);
            ex(0, 0, 1600, sw_seq[k]);
        end
        send(240, 100);

        // relock collides with the win_done that would promote PULL to TRACK
        ex(0, 0, 80, 0);
        ex(1, 0, 80, 0);
        ex(3, 1, 80, 0);
        ex(0, 0, 80, 0);
        ex(0, 0, 320, 0);
        send(64, 5);
        @(negedge clk); pd = 300;
        @(negedge clk); pd = 300;
        @(negedge clk); pd = 300; relock = 1'b1;
        @(negedge clk); relock = 1'b0; en = 1'b0;
        chk("relock_lost", state, 3);
        chk("relock_clr", loop_clr, 1);
        send(16, 20);

        // Saturated |pd| with en toggling: 16 accepted samples over 32 cycles
        ex(0, 0, M_SAT, 0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); en = 1'b1; pd = PW'(-67108864);
            @(negedge clk); en = 1'b0;
        end
        @(negedge clk);
        chk("sat_metric_not_early", metric, 320);
        @(negedge clk);
        chk("sat_metric", metric, M_SAT);

        // Held relock keeps loop_clr high
        ex(3, 1, M_SAT, 0);
        ex(0, 0, M_SAT, 0);
        @(negedge clk); relock = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("relock_hold_state", state, 3);
            chk("relock_hold_clr", loop_clr, 1);
        end
        relock = 1'b0;
        @(negedge clk);
        chk("relock_release_state", state, 0);
        chk("relock_release_clr", loop_clr, 0);

        // Reset mid-operation
        send(8, 5);
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        chk("midreset_state", state, 0);
        chk("midreset_gain", gain_sel, 0);
        chk("midreset_locked", locked, 0);
        chk("midreset_loop_clr", loop_clr, 0);
        chk("midreset_metric", metric, 0);

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/qam_carrier_ctrl.md
# qam_carrier_ctrl

Acquisition/tracking sequencer for the 16QAM carrier-recovery loop. Monitors the phase-detector output over fixed windows, decides lock state with hysteresis, and drives the loop-filter bandwidth select and integrator clear. Optionally steps a coarse NCO frequency offset during failed acquisition. Sits beside the phase detector and loop filter in the carrier-recovery top level, on the 8 MHz sample clock.

## Interface
Parameters:
- PW, 27: phase-detector word width (signed).
- WIN_LOG2, 10: window length = 2^WIN_LOG2 accepted samples.
- LOCK_TH, 2^30: window metric strictly below this is a "good" window.
- UNLOCK_TH, 2^32: window metric at or above this is a "bad" window; UNLOCK_TH > LOCK_TH is required.
- LOCK_CNT, 4: consecutive qualifying windows needed to advance or to declare loss.
- ACQ_TIMEOUT, 64: windows in ACQ before re-clearing the loop.
- SWEEP_STEP, 2^16: sweep increment (PW-bit signed units).
- SWEEP_MAX, 2^20: sweep magnitude limit.

Ports:
- clk  in  1  sample/system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  pd valid this cycle.
- pd  in  PW  signed phase error.
- relock  in  1  software re-acquire request, level-sampled.
- state  out  2  0=ACQ, 1=PULL, 2=TRACK, 3=LOST.
- gain_sel  out  2  loop-filter bandwidth: 0 wide, 1 medium, 2 narrow.
- loop_clr  out  1  one-cycle pulse that clears the loop-filter integrator.
- locked  out  1  high only in TRACK.
- metric  out  PW+WIN_LOG2  last completed window sum of |pd|, unsigned.
- sweep_df  out  PW  signed NCO frequency offset, added to the loop output upstream of the NCO.

## Operation
- Stage 1, registered: abs_pd = |pd|, with -2^(PW-1) saturated to 2^(PW-1)-1. en is delayed alongside.
- Stage 2 accumulator: adds abs_pd on each delayed en. The window counter counts delayed en.
- On the last sample of a window: metric <= acc + abs_pd, acc <= 0, win_done pulses on the next cycle.
- Accumulator width PW+WIN_LOG2. Overflow is impossible by construction.
- State register, evaluated on win_done:
  - ACQ (gain 0):
    - metric < LOCK_TH increments good_cnt; otherwise good_cnt <= 0.
    - When good_cnt reaches LOCK_CNT, go to PULL.
    - Otherwise the timeout counter increments. When it reaches ACQ_TIMEOUT: loop_clr pulses, the timeout counter clears, state stays ACQ, and a sweep step is taken.
  - PULL (gain 1):
    - Same good_cnt rule. When it reaches LOCK_CNT, go to TRACK.
    - Any metric >= UNLOCK_TH: go to ACQ with a loop_clr pulse.
  - TRACK (gain 2, locked=1):
    - metric >= UNLOCK_TH increments bad_cnt; otherwise bad_cnt <= 0.
    - When bad_cnt reaches LOCK_CNT, go to LOST.
  - LOST: lasts exactly one cycle. Asserts loop_clr and clears all counters, then goes to ACQ.
- Every state change clears good_cnt, bad_cnt and the timeout counter.
- relock=1 in any state forces LOST on the next edge. It overrides a coincident win_done and also clears acc, the window counter and the pipeline valid.
- A metric between the two thresholds is neutral: it resets good_cnt and resets bad_cnt.

## Timing
- Reset values:
  - state=ACQ, gain_sel=0, loop_clr=0, locked=0.
  - metric=0, sweep_df=0.
  - All counters 0.
- Latency:
  - Edge E: last en sample of a window is registered.
  - E+1: abs_pd is registered.
  - E+2: metric is updated.
  - E+3: state, gain_sel and locked reflect the decision.
- loop_clr is asserted in the same cycle as the new state.
- gain_sel and locked decode from the state register: no extra cycle.
- Samples with en=0 are ignored entirely. Window length is counted in accepted samples, not cycles.
- relock is sampled every cycle. A held relock keeps re-entering LOST, so loop_clr stays high while relock is held.

## Configuration
- CARRIER_SWEEP_EN defined:
  - Each ACQ timeout advances sweep_df through 0, +S, -S, +2S, -2S, … with S = SWEEP_STEP.
  - After reaching ±SWEEP_MAX the sequence restarts at 0.
  - sweep_df holds in PULL, TRACK and LOST. It resets to 0 only on rst or relock.
- CARRIER_SWEEP_EN undefined: the sweep logic is absent and sweep_df is constant 0. The port remains.

## Test plan
Bench overrides: WIN_LOG2=4, LOCK_TH=160, UNLOCK_TH=480, LOCK_CNT=2, ACQ_TIMEOUT=3, SWEEP_STEP=10, SWEEP_MAX=20; en=1 unless stated.
- Reset: rst high for 3 cycles mid-operation -> state=0, gain_sel=0, locked=0, loop_clr=0, metric=0 the cycle after reset.
- Acquire: pd=+5 constant -> metric=80.
  - state=PULL 3 cycles after sample 32; TRACK after sample 64; gain_sel 1 then 2; locked=1.
  - No loop_clr pulse occurs.
- Loss and hysteresis, starting in TRACK:
  - One window of pd=-40 (metric 640), then pd=5 -> stays TRACK.
  - Two consecutive windows of pd=-40 -> LOST for one cycle with loop_clr=1, then ACQ; locked=0.
- Timeout and sweep: pd=100 constant (metric 1600) in ACQ.
  - loop_clr pulses every 3 windows.
  - With CARRIER_SWEEP_EN: sweep_df goes 0, 10, -10, 20, -20, 0.
  - Without it: sweep_df stays 0.
- relock collision: assert relock in the same cycle as a win_done that would advance PULL to TRACK -> state=LOST, then ACQ; the next window's metric covers only the new 16 samples.
- Saturation and gating:
  - pd=-2^26 for 16 samples, alternating en=1/0 -> metric = 16×(2^26-1).
  - The window closes after 16 accepted samples, about 32 cycles.
